// File: rtl/tetris_engine.sv
// Tetris-style playfield controller: 10x16 board, 2x2 falling piece, gravity timer.
// Define TETRIS_LINE_CLEAR_EN to remove full rows during GEN; otherwise full rows persist.
module tetris_engine #(
  parameter int DROP_TICKS = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Ack,
  input  logic         Left,
  input  logic         Right,
  input  logic         Down,
  output logic         q_I,
  output logic         q_Gen,
  output logic         q_Rot,
  output logic         q_Col,
  output logic [159:0] blocks
);

  localparam int CNT_W = $clog2(DROP_TICKS);

  // The state register is itself one-hot, so the state outputs are registered bits.
  typedef enum logic [3:0] {
    S_I   = 4'b0001,
    S_GEN = 4'b0010,
    S_ROT = 4'b0100,
    S_COL = 4'b1000
  } state_t;

  state_t             state;
  logic [15:0][9:0]   board;     // board[r][c] is blocks bit r*10+c
  logic [15:0][9:0]   piece;
  logic [15:0][9:0]   cleared;
  logic [3:0]         pr, pc;
  logic [CNT_W-1:0]   cnt;

  logic [3:0] pr_dn, pr_dn2, pc_l, pc_p1, pc_r2;
  logic       can_fall, can_left, can_right, spawn_hit, drop_step, clear_now;

  assign pr_dn  = pr + 4'd1;
  assign pr_dn2 = pr + 4'd2;
  assign pc_l   = pc - 4'd1;
  assign pc_p1  = pc + 4'd1;
  assign pc_r2  = pc + 4'd2;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    piece            = '0;
    piece[pr][pc]    = 1'b1;
    piece[pr][pc_p1] = 1'b1;
    piece[pr_dn][pc]    = 1'b1;
    piece[pr_dn][pc_p1] = 1'b1;
  end

  // Edge checks short-circuit before any out-of-range row/column is consulted.
  assign can_fall  = (pr < 4'd14) && !board[pr_dn2][pc] && !board[pr_dn2][pc_p1];
  assign can_left  = (pc != 4'd0) && !board[pr][pc_l]  && !board[pr_dn][pc_l];
  assign can_right = (pc < 4'd8)  && !board[pr][pc_r2] && !board[pr_dn][pc_r2];
  assign spawn_hit = board[0][4] | board[0][5] | board[1][4] | board[1][5];
  assign drop_step = Down || (cnt == CNT_W'(DROP_TICKS - 1));

`ifdef TETRIS_LINE_CLEAR_EN
  logic [15:0]      row_full;
  logic [3:0]       clr_row;
  logic [15:0][9:0] shifted;

  assign shifted = {board[14:0], 10'b0};

  // Lowest full row is the one with the largest index; rows at or above it drop by one.
  always_comb begin
    clr_row  = 4'd0;
    row_full = '0;
    cleared  = board;
    for (int r = 0; r < 16; r++) begin
      row_full[r] = &board[r];
      if (row_full[r]) clr_row = 4'(r);
    end
    for (int r = 0; r < 16; r++) begin
      if (4'(r) <= clr_row) cleared[r] = shifted[r];
    end
  end

  assign clear_now = |row_full;
`else
  assign clear_now = 1'b0;
  assign cleared   = board;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      // NOTE: the board storage is reset because every game must start from an empty field.
      state <= S_I;
      board <= '0;
      pr    <= '0;
      pc    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_I: begin
          if (Start) state <= S_GEN;
        end
        S_GEN: begin
          if (clear_now) begin
            board <= cleared;
          end else begin
            pr    <= 4'd0;
            pc    <= 4'd4;
            cnt   <= '0;
            state <= spawn_hit ? S_COL : S_ROT;
          end
        end
        S_ROT: begin
          if (drop_step) begin
            cnt <= '0;
            if (can_fall) begin
              pr <= pr_dn;
            end else begin
              board <= board | piece;
              state <= S_GEN;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (Left) begin
              if (can_left) pc <= pc_l;
            end else if (Right) begin
              if (can_right) pc <= pc_p1;
            end
          end
        end
        S_COL: begin
          if (Ack) begin
            board <= '0;
            state <= S_I;
          end
        end
        default: state <= S_I;
      endcase
    end
  end

  assign q_I   = state[0];
  assign q_Gen = state[1];
  assign q_Rot = state[2];
  assign q_Col = state[3];

  assign blocks = board | (q_Rot ? piece : '0);

endmodule

// File: tb/tb_tetris_engine.sv
// Scoreboard bench for tetris_engine: a behavioural playfield model predicts state and
// board image per clock; a handful of fixed images anchor the key scenarios.
module tb_tetris_engine;

  localparam int DROP_TICKS = 16;
  localparam int M_I = 0, M_GEN = 1, M_ROT = 2, M_COL = 3;

  logic         Clk_tb = 1'b0;
  logic         Reset, Start, Ack, Left, Right, Down;
  logic         q_I, q_Gen, q_Rot, q_Col;
  logic [159:0] blocks;

  tetris_engine #(.DROP_TICKS(DROP_TICKS)) dut (
    .Clk   (Clk_tb),
    .Reset (Reset),
    .Start (Start),
    .Ack   (Ack),
    .Left  (Left),
    .Right (Right),
    .Down  (Down),
    .q_I   (q_I),
    .q_Gen (q_Gen),
    .q_Rot (q_Rot),
    .q_Col (q_Col),
    .blocks(blocks)
  );

  always #5 Clk_tb = ~Clk_tb;

  typedef struct {
    logic [3:0]   st;
    logic [159:0] img;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           ms, mpr, mpc, mcnt;
  logic [159:0] mb;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [159:0] piece_bits(input int r, input int c);
    logic [159:0] m = '0;
    m[r*10 + c]         = 1'b1;
    m[r*10 + c + 1]     = 1'b1;
    m[(r+1)*10 + c]     = 1'b1;
    m[(r+1)*10 + c + 1] = 1'b1;
    return m;
  endfunction

  function automatic bit occ(input int r, input int c);
    return mb[r*10 + c];
  endfunction

  task automatic model_step(input bit rst_v, input bit st, input bit ak,
                            input bit l, input bit r, input bit d);
    int full_row;
    full_row = -1;
    if (!rst_v) begin
      ms = M_I; mb = '0; mpr = 0; mpc = 0; mcnt = 0;
      return;
    end
    case (ms)
      M_I: if (st) ms = M_GEN;
      M_GEN: begin
`ifdef TETRIS_LINE_CLEAR_EN
        for (int row = 0; row < 16; row++)
          if (mb[row*10 +: 10] == 10'h3ff) full_row = row;
`endif
        if (full_row >= 0) begin
          for (int row = full_row; row > 0; row--) mb[row*10 +: 10] = mb[(row-1)*10 +: 10];
          mb[9:0] = '0;
        end else begin
          mpr = 0; mpc = 4; mcnt = 0;
          ms = (occ(0,4) || occ(0,5) || occ(1,4) || occ(1,5)) ? M_COL : M_ROT;
        end
      end
      M_ROT: begin
        if (d || mcnt == DROP_TICKS - 1) begin
          mcnt = 0;
          if (mpr < 14 && !occ(mpr+2, mpc) && !occ(mpr+2, mpc+1)) mpr++;
          else begin
            mb = mb | piece_bits(mpr, mpc);
            ms = M_GEN;
          end
        end else begin
          mcnt++;
          if (l) begin
            if (mpc > 0 && !occ(mpr, mpc-1) && !occ(mpr+1, mpc-1)) mpc--;
          end else if (r) begin
            if (mpc < 8 && !occ(mpr, mpc+2) && !occ(mpr+1, mpc+2)) mpc++;
          end
        end
      end
      M_COL: if (ak) begin ms = M_I; mb = '0; end
      default: ms = M_I;
    endcase
  endtask

  // Drive one clock of stimulus, predict its outcome, then compare after the edge.
  task automatic step(input bit rst_v, input bit st, input bit ak,
                      input bit l, input bit r, input bit d);
    exp_t e;
    @(negedge Clk_tb);
    Reset = rst_v; Start = st; Ack = ak; Left = l; Right = r; Down = d;
    model_step(rst_v, st, ak, l, r, d);
    e.st  = 4'(1 << ms);
    e.img = mb | ((ms == M_ROT) ? piece_bits(mpr, mpc) : '0);
    exp_q.push_back(e);
    @(posedge Clk_tb);
    #1;
    e = exp_q.pop_front();
    check("state", 160'({q_Col, q_Rot, q_Gen, q_I}), 160'(e.st));
    check("blocks", blocks, e.img);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Hold Down (optionally with Right) until the piece locks; returns clocks taken.
  task automatic drop_piece(input bit r, output int n);
    n = 0;
    while (n < 20) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, r, 1'b1);
      n++;
      if (ms == M_GEN) break;
    end
    if (ms != M_GEN) check("drop_timeout", 160'(q_Gen), 160'(1));
  endtask

  logic [159:0] bottom, stack_img;
  int           n_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; Start = 1'b0; Ack = 1'b0; Left = 1'b0; Right = 1'b0; Down = 1'b0;
    bottom = {20'hfffff, 140'b0};

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_qI", 160'(q_I), 160'(1));
    check("rst_blocks", blocks, '0);
    repeat (5) idle();
    check("idle_hold", 160'(q_I), 160'(1));

    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("gen_after_start", 160'(q_Gen), 160'(1));
    idle();
    check("spawn_img", blocks, piece_bits(0, 4));

    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("left2", blocks, piece_bits(0, 2));
    for (int i = 3; i <= 28; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (i == 15) check("right_sat", blocks, piece_bits(0, 8));
      if (i == 16) check("gravity16", blocks, piece_bits(1, 8));
    end
    repeat (4) idle();
    check("gravity32", blocks, piece_bits(2, 8));

    drop_piece(1'b0, n_clk);
    check("lock1_img", blocks, piece_bits(14, 8));
    idle();
    check("respawn", blocks, piece_bits(14, 8) | piece_bits(0, 4));
    drop_piece(1'b0, n_clk);
    check("lock_latency", 160'(n_clk), 160'(15));
    check("lock2_img", blocks, piece_bits(14, 8) | piece_bits(14, 4));

    idle();
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("left_priority", blocks, piece_bits(14, 8) | piece_bits(14, 4) | piece_bits(0, 0));
    drop_piece(1'b1, n_clk);
    check("down_over_right", blocks, piece_bits(14, 8) | piece_bits(14, 4) | piece_bits(14, 0));

    idle();
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drop_piece(1'b0, n_clk);
    idle();
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drop_piece(1'b0, n_clk);
    check("rows_full", blocks, bottom);

`ifdef TETRIS_LINE_CLEAR_EN
    idle();
    check("clear1_gen", 160'(q_Gen), 160'(1));
    idle();
    check("clear2_gen", 160'(q_Gen), 160'(1));
    check("clear2_empty", blocks, '0);
    stack_img = '0;
    for (int r = 0; r <= 14; r += 2) stack_img = stack_img | piece_bits(r, 4);
`else
    stack_img = bottom;
    for (int r = 0; r <= 12; r += 2) stack_img = stack_img | piece_bits(r, 4);
`endif

    for (int p = 0; p < 16 && ms != M_COL; p++) begin
      idle();
      if (ms == M_ROT) drop_piece(1'b0, n_clk);
    end
    check("game_over", 160'(q_Col), 160'(1));
    check("col_img", blocks, stack_img);

    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("col_frozen", blocks, stack_img);
    check("col_ignores_start", 160'(q_Col), 160'(1));
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ack_idle", 160'(q_I), 160'(1));
    check("ack_clears", blocks, '0);

    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("midgame_piece", blocks, piece_bits(0, 3));
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("midgame_reset_state", 160'(q_I), 160'(1));
    check("midgame_reset_img", blocks, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tetris_engine.md
# tetris_engine

Single-clock Tetris-style playfield controller. Maintains a 10-column × 16-row occupancy board, spawns a 2×2 falling piece, and moves it left, right and down under player inputs and a gravity timer. Locks landed pieces and optionally clears full rows. Exposes its one-hot state and the composited board (settled cells plus live piece) to the display/top-level logic.

## Interface
- DROP_TICKS, 16, gravity period in clocks while a piece is live (≥2)
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-low reset
- Start  in  1  begin game (sampled in I only)
- Ack  in  1  acknowledge game over (sampled in COL only)
- Left  in  1  level: shift piece one column left per clock
- Right  in  1  level: shift piece one column right per clock
- Down  in  1  level: force one-row descent per clock
- q_I  out  1  state I (idle)
- q_Gen  out  1  state GEN (clear/spawn)
- q_Rot  out  1  state ROT (piece live)
- q_Col  out  1  state COL (game over)
- blocks  out  160  board image; bit r*10+c, row 0 = top, col 0 = left

One clock; reset is synchronous and active-low (Clk, Reset).

## Operation
- Board: 160 registered bits. Piece: row pr (0..14) and column pc (0..8); covers (pr,pc), (pr,pc+1), (pr+1,pc), (pr+1,pc+1).
- blocks = board OR piece cells when in ROT; board only in other states.
- State outputs are one-hot and registered.
- I: Start=1 → GEN.
- GEN, per cycle:
  - If TETRIS_LINE_CLEAR_EN and any row is full: clear the lowest full row, shift every row above it down by one, zero row 0, stay in GEN.
  - Otherwise spawn with pr=0, pc=4.
  - If any spawn cell is occupied → COL, and the piece is not drawn.
  - Else → ROT, with the drop counter at 0.
- ROT, per cycle, evaluated against the current position:
  - Vertical step fires when Down=1 or the drop counter = DROP_TICKS-1.
  - On a vertical step:
    - If pr<14 and both cells below are free: pr+1, counter←0.
    - Else: OR piece into board, counter←0, → GEN.
    - Horizontal input is ignored in that cycle.
  - Otherwise the counter increments and a horizontal move is applied:
    - Left has priority over Right.
    - Left moves if pc>0 and both target cells are free.
    - Right moves if pc<8 and both target cells are free.
    - A blocked move is a no-op.
- COL: board frozen. Ack=1 → I and the board clears in the same edge. Start is ignored.
- Reset=0: state I, board=0, pr=pc=0, counter=0.

## Timing
- Reset values: q_I=1, q_Gen=q_Rot=q_Col=0, blocks=0.
- Start high at edge k → q_Gen at k+1.
- With no full rows: q_Rot and piece visible at k+2.
- Each held Left/Right cycle moves exactly one column (1-cycle latency).
- Without Down, gravity moves the piece every DROP_TICKS clocks.
- With Down held: one row per clock.
- Lock occurs on the edge where descent fails → GEN the next cycle.
- Each full row costs one GEN cycle before spawn.
- Reset mid-game (any state) takes effect on the next edge and overrides all other inputs.
- Left+Right together: Left wins. Down with Left/Right: only the descent happens.

## Configuration
- TETRIS_LINE_CLEAR_EN defined: GEN removes full rows as above.
- Not defined: no row clearing. GEN always spawns on its first cycle, and full rows persist.

## Test plan
- Reset=0 for one cycle → q_I=1, blocks=0. Hold Start=0 for 5 cycles → stays in I.
- Start pulse → q_Gen next cycle, then q_Rot with blocks bits 4,5,14,15 set and all other bits clear.
- In ROT, Left for 2 cycles → pc=2 (bits 2,3,12,13). Then Right held 26 cycles → pc saturates at 8 (cols 8,9). Gravity descends at cycles 16 and 32 of ROT.
- Down held from spawn → piece reaches pr=14 after 14 clocks, locks on the 15th (bits 144,145,154,155 in board), GEN, new piece at pc=4.
- LINE_CLEAR_EN: drop pieces at pc 0,2,4,6,8 → after the fifth lock, two GEN cycles clear rows 15 and 14, board=0, then spawn. Without the macro → rows 14–15 remain full.
- Stack pieces at pc=4 with Down until spawn is blocked → q_Col=1 and board frozen. Start ignored. Ack → q_I=1 and blocks=0.
